testeio_pio_in_edge: RTL and testbench
======================================

Name: testeio_pio_in_edge

Overview:
- Parametrised Avalon-MM input PIO.
- Successor to the fixed 8-bit read-only input port. Adds:
  - configurable width;
  - metastability synchroniser;
  - per-bit edge capture with write-1-to-clear;
  - interrupt mask register and registered interrupt output.
- Sits between external pins (switches, buttons, sensor strobes) and the Nios/Avalon fabric in the testeio system.

Parameters:
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flop count on in_port, 2..4.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- RESET_MASK, 0: reset value of irqmask, WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered Avalon read data.
- irq  out  1  registered interrupt request, active high.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - all sync flops, prev, edgecapture = 0;
  - irqmask = RESET_MASK;
  - readdata = 0;
  - irq = 0.
- Synchroniser:
  - s[0] <= in_port; s[i] <= s[i-1]; sync = s[SYNC_STAGES-1].
  - prev <= sync every cycle.
- Edge detect (combinational), per bit:
  - rise = sync & ~prev; fall = ~sync & prev.
  - edge = rise, fall or (rise | fall), per EDGE_TYPE.
- Register map. Write strobe wr = chipselect & ~write_n.
  - addr 0, data: read-only; returns sync. Writes are ignored.
  - addr 1: reserved. Reads 0; writes ignored.
  - addr 2, irqmask: R/W. When wr, irqmask <= writedata[WIDTH-1:0].
  - addr 3, edgecapture: read; write-1-to-clear per bit.
- Edgecapture update each cycle: edgecapture <= (edgecapture & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] when wr and address == 3, else 0.
  - Set wins over clear in the same cycle, so no edge is lost.
- Readdata:
  - readdata <= zero-extended mux(address), updated every clock regardless of chipselect.
  - Read latency is 1 cycle.
  - Bits [31:WIDTH] are always 0.
- irq <= |(edgecapture & irqmask), registered. It stays asserted until the captured bits are cleared or masked.
- Latency, in_port edge arriving before clk edge k:
  - sync changes after edge k+SYNC_STAGES-1;
  - edgecapture bit set after edge k+SYNC_STAGES;
  - irq high after edge k+SYNC_STAGES+1;
  - addr-0 readdata reflects the new value after edge k+SYNC_STAGES.
- Writes with writedata bits above WIDTH: those bits are ignored.
- Pulses shorter than one clk period may be missed. This is not guaranteed capture.
- Reset asserted mid-operation clears pending captures and irq immediately (asynchronous). After release, the first cycle sees prev = 0. With in_port held high, a rising edge is therefore captured SYNC_STAGES+1 cycles after reset release. This is intended and documented for software.

Test Plan:
1. Reset and idle:
   - Assert reset with in_port = 8'hA5, WIDTH = 8.
   - Required: readdata = 0, irq = 0, irqmask reads RESET_MASK.
   - After release, addr 0 reads 32'h000000A5 within SYNC_STAGES+1 cycles.
2. Read latency:
   - in_port stable at 8'h3C, address changes 0 -> 3 on consecutive cycles.
   - Required: readdata shows 32'h3C, then the edgecapture value, each exactly one cycle after its address.
3. Rising capture and irq:
   - irqmask = 8'h01; in_port bit0 0 -> 1 before edge k.
   - Required: edgecapture = 8'h01 after edge k+2; irq = 1 after edge k+3.
   - Write 8'h01 to addr 3: edgecapture = 0; irq drops the next cycle.
4. Set/clear collision:
   - Bit2 edge arrives in the same cycle as a write of 8'h04 to addr 3.
   - Required: bit2 remains 1.
   - A write of 8'h02 clears only bit1.
5. Masking:
   - edgecapture = 8'h80 with irqmask = 0 -> irq stays 0.
   - Write irqmask 8'h80 -> irq = 1 one cycle later.
6. EDGE_TYPE = 2, WIDTH = 32:
   - Toggle bit31 high then low, clearing in between.
   - Required: both transitions captured; readdata[31] correct; no upper-bit leakage with WIDTH = 5 (readdata[31:5] = 0).

Source files
------------

// File: rtl/testeio_pio_in_edge.sv
// Parametrised Avalon-MM input PIO: synchronised pins, per-bit edge capture
// with write-1-to-clear, interrupt mask and a registered interrupt request.
module testeio_pio_in_edge #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned DW        = 32;
  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_RSVD = 2'd1;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_c;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DW-1:0]    readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_c;
  logic [WIDTH-1:0] rise_c, fall_c, edge_c, clr_c;
  logic             unused_wdata;

  // Bits of writedata above WIDTH are architecturally ignored.
  assign unused_wdata = ^writedata;

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Metastability chain on the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Next-state for capture, mask, read mux and interrupt.
  always_comb begin
    wr_c       = chipselect & ~write_n;
    rise_c     = sync_c & ~prev_q;
    fall_c     = ~sync_c & prev_q;
    edge_c     = rise_c | fall_c;
    clr_c      = '0;
    edgecap_d  = edgecap_q;
    irqmask_d  = irqmask_q;
    readdata_d = '0;
    irq_d      = |(edgecap_q & irqmask_q);

    if (EDGE_TYPE == 0) begin
      edge_c = rise_c;
    end else if (EDGE_TYPE == 1) begin
      edge_c = fall_c;
    end

    if (wr_c && (address == ADDR_EDGE)) begin
      clr_c = writedata[WIDTH-1:0];
    end
    // A fresh edge always survives a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~clr_c) | edge_c;

    if (wr_c && (address == ADDR_MASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end

    case (address)
      ADDR_DATA: readdata_d = DW'(sync_c);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = DW'(irqmask_q);
      ADDR_EDGE: readdata_d = DW'(edgecap_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= RESET_MASK;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= sync_c;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_testeio_pio_in_edge.sv
// Bench for testeio_pio_in_edge: three configurations on a shared bus, a
// hand-derived vector table, corner-case sequences and a random model run.
module tb_testeio_pio_in_edge;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  testeio_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(8'h00)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port[7:0]), .readdata(rd0), .irq(irq0));

  testeio_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2), .RESET_MASK(32'h8000_0001)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));

  testeio_pio_in_edge #(.WIDTH(5), .SYNC_STAGES(4), .EDGE_TYPE(1), .RESET_MASK(5'h11)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port[4:0]), .readdata(rd2), .irq(irq2));

  // Reference model: pins sampled at each edge since reset release; sync is
  // simply the sample taken SYNC_STAGES-1 edges earlier.
  logic [31:0] samp[$];
  logic [31:0] m_ec   [NDUT];
  logic [31:0] m_mask [NDUT];
  logic [31:0] m_rd   [NDUT];
  logic        m_irq  [NDUT];

  function automatic int cfg_w(int d);
    case (d) 0: return 8; 1: return 32; default: return 5; endcase
  endfunction
  function automatic int cfg_s(int d);
    case (d) 0: return 2; 1: return 3; default: return 4; endcase
  endfunction
  function automatic int cfg_t(int d);
    case (d) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic logic [31:0] cfg_rm(int d);
    case (d) 0: return 32'h0; 1: return 32'h8000_0001; default: return 32'h11; endcase
  endfunction
  function automatic logic [31:0] wmask(int d);
    return (cfg_w(d) == 32) ? 32'hFFFF_FFFF : ((32'h1 << cfg_w(d)) - 32'h1);
  endfunction
  function automatic logic [31:0] sample_at(int j);
    return (j >= 1 && j <= samp.size()) ? samp[j-1] : 32'h0;
  endfunction

  function automatic void model_reset();
    samp.delete();
    for (int d = 0; d < NDUT; d++) begin
      m_ec[d] = 32'h0; m_mask[d] = cfg_rm(d); m_rd[d] = 32'h0; m_irq[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int n = samp.size() + 1;
    logic wr = chipselect && !write_n;
    for (int d = 0; d < NDUT; d++) begin
      logic [31:0] wm = wmask(d);
      logic [31:0] sy = sample_at(n - cfg_s(d)) & wm;
      logic [31:0] pv = sample_at(n - 1 - cfg_s(d)) & wm;
      logic [31:0] rise = sy & ~pv & wm;
      logic [31:0] fall = ~sy & pv & wm;
      logic [31:0] e = (cfg_t(d) == 0) ? rise : (cfg_t(d) == 1) ? fall : (rise | fall);
      logic [31:0] clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
      m_irq[d] = |(m_ec[d] & m_mask[d]);
      case (address)
        2'd0: m_rd[d] = sy;
        2'd1: m_rd[d] = 32'h0;
        2'd2: m_rd[d] = m_mask[d];
        default: m_rd[d] = m_ec[d];
      endcase
      m_ec[d] = (m_ec[d] & ~clr) | e;
      if (wr && address == 2'd2) m_mask[d] = writedata & wm;
    end
    samp.push_back(in_port);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] dut_rd(int d);
    case (d) 0: return rd0; 1: return rd1; default: return rd2; endcase
  endfunction
  function automatic logic dut_irq(int d);
    case (d) 0: return irq0; 1: return irq1; default: return irq2; endcase
  endfunction

  function automatic void compare_model();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("model_rd%0d", d), dut_rd(d), m_rd[d]);
      check($sformatf("model_irq%0d", d), 32'(dut_irq(d)), 32'(m_irq[d]));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(logic [1:0] a, logic w, logic [31:0] wd, logic [7:0] inp,
                              logic [31:0] er, logic ei);
    vec_t v;
    v.addr = a; v.wr = w; v.wd = wd; v.inp = inp; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  initial begin
    // Expected values for the WIDTH=8, 2-stage, rising-edge instance.
    vecs[0]  = mk(2'd0, 0, 32'h0,   8'h3C, 32'h00, 0);
    vecs[1]  = mk(2'd0, 0, 32'h0,   8'h3C, 32'h00, 0);
    vecs[2]  = mk(2'd0, 0, 32'h0,   8'h3C, 32'h3C, 0);
    vecs[3]  = mk(2'd1, 0, 32'h0,   8'h3C, 32'h00, 0);
    vecs[4]  = mk(2'd2, 0, 32'h0,   8'h3C, 32'h00, 0);
    vecs[5]  = mk(2'd3, 0, 32'h0,   8'h3C, 32'h3C, 0);
    vecs[6]  = mk(2'd3, 1, 32'hFF,  8'h3C, 32'h3C, 0);
    vecs[7]  = mk(2'd2, 1, 32'h101, 8'h3C, 32'h00, 0);
    vecs[8]  = mk(2'd2, 0, 32'h0,   8'h3C, 32'h01, 0);
    vecs[9]  = mk(2'd3, 0, 32'h0,   8'h3D, 32'h00, 0);
    vecs[10] = mk(2'd3, 0, 32'h0,   8'h3D, 32'h00, 0);
    vecs[11] = mk(2'd3, 0, 32'h0,   8'h3D, 32'h00, 0);
    vecs[12] = mk(2'd3, 0, 32'h0,   8'h3D, 32'h01, 1);
    vecs[13] = mk(2'd3, 1, 32'h01,  8'h3D, 32'h01, 1);
    vecs[14] = mk(2'd3, 0, 32'h0,   8'h3D, 32'h00, 0);
    vecs[15] = mk(2'd0, 0, 32'h0,   8'h39, 32'h3D, 0);
    vecs[16] = mk(2'd0, 0, 32'h0,   8'h39, 32'h3D, 0);
    vecs[17] = mk(2'd0, 0, 32'h0,   8'h39, 32'h39, 0);
    vecs[18] = mk(2'd3, 0, 32'h0,   8'h3F, 32'h00, 0);
    vecs[19] = mk(2'd3, 0, 32'h0,   8'h3F, 32'h00, 0);
    vecs[20] = mk(2'd3, 1, 32'h04,  8'h3F, 32'h00, 0);
    vecs[21] = mk(2'd3, 0, 32'h0,   8'h3F, 32'h06, 0);
    vecs[22] = mk(2'd3, 1, 32'h02,  8'h3F, 32'h06, 0);
    vecs[23] = mk(2'd3, 0, 32'h0,   8'h3F, 32'h04, 0);
    vecs[24] = mk(2'd2, 1, 32'h00,  8'hBF, 32'h01, 0);
    vecs[25] = mk(2'd3, 1, 32'h04,  8'hBF, 32'h04, 0);
    vecs[26] = mk(2'd3, 0, 32'h0,   8'hBF, 32'h00, 0);
    vecs[27] = mk(2'd3, 0, 32'h0,   8'hBF, 32'h80, 0);
    vecs[28] = mk(2'd2, 1, 32'h80,  8'hBF, 32'h00, 0);
    vecs[29] = mk(2'd2, 0, 32'h0,   8'hBF, 32'h80, 1);
    vecs[30] = mk(2'd0, 0, 32'h0,   8'hBF, 32'hBF, 1);

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 32'hA5;
    model_reset();

    // Reset with pins high, then the synchronised value appears on addr 0.
    ticks(2);
    check("reset_rd0", rd0, 32'h0);
    check("reset_irq0", 32'(irq0), 32'h0);
    reset = 1'b0;
    ticks(3);
    check("post_reset_data", rd0, 32'h0000_00A5);
    address = 2'd2;
    tick();
    check("reset_mask0", rd0, 32'h00);
    check("reset_mask1", rd1, 32'h8000_0001);
    check("reset_mask2", rd2, 32'h11);
    address = 2'd1;
    ticks(4);

    // Asynchronous reset mid-operation clears outputs without a clock.
    reset = 1'b1;
    in_port = 32'h0;
    model_reset();
    #1;
    check("async_rst_irq2", 32'(irq2), 32'h0);
    check("async_rst_rd0", rd0, 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(6);

    for (int r = 0; r < 31; r++) begin
      address    = vecs[r].addr;
      chipselect = 1'b1;
      write_n    = !vecs[r].wr;
      writedata  = vecs[r].wd;
      in_port    = {24'h0, vecs[r].inp};
      tick();
      check($sformatf("vec%0d_rd", r), rd0, vecs[r].exp_rd);
      check($sformatf("vec%0d_irq", r), 32'(irq0), 32'(vecs[r].exp_irq));
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Any-edge capture on bit 31 of the 32-bit instance.
    in_port = 32'h0; address = 2'd3; chipselect = 1'b1;
    ticks(6);
    write_n = 1'b0; writedata = 32'hFFFF_FFFF;
    tick();
    write_n = 1'b1;
    tick();
    in_port = 32'h8000_0000;
    ticks(5);
    check("w32_rise", rd1, 32'h8000_0000);
    write_n = 1'b0; writedata = 32'h8000_0000;
    tick();
    write_n = 1'b1;
    in_port = 32'h0;
    ticks(5);
    check("w32_fall", rd1, 32'h8000_0000);

    // Upper bits of a narrow instance never leak.
    in_port = 32'hFFFF_FFFF; address = 2'd0;
    ticks(6);
    check("w5_data", rd2, 32'h0000_001F);
    check("w5_upper", 32'(rd2[31:5]), 32'h0);
    check("w32_data", rd1, 32'hFFFF_FFFF);

    // Randomised traffic with sparse pin toggles and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        compare_model();
        tick();
        reset = 1'b0;
      end
      in_port    = in_port ^ ($urandom & $urandom & $urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
